// File: rtl/irq_priority_controller.sv
// rtl/irq_priority_controller.sv - nested rotating-priority interrupt controller core
module irq_priority_controller #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ),
  parameter int VEC_W   = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_IRQ-1:0]     irq_in,
  input  logic                   level_mode,
  input  logic [VEC_W-IDX_W-1:0] vector_base,
  input  logic                   imr_wr,
  input  logic [NUM_IRQ-1:0]     imr_data,
  input  logic                   auto_eoi,
  input  logic                   rotate_on_aeoi,
  input  logic                   eoi_valid,
  input  logic                   eoi_specific,
  input  logic [IDX_W-1:0]       eoi_id,
  input  logic                   eoi_rotate,
  input  logic                   inta_pulse,
  output logic                   int_out,
  output logic                   vector_valid,
  output logic [VEC_W-1:0]       vector,
  output logic [NUM_IRQ-1:0]     irr,
  output logic [NUM_IRQ-1:0]     isr,
  output logic [NUM_IRQ-1:0]     imr
);

  typedef enum logic {S_IDLE, S_ACK1} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_IRQ-1:0] r_irq_q, r_irr, r_isr, r_imr;
  logic [IDX_W-1:0]   r_lowest_ptr, r_ack_id;
  logic               r_spurious, r_int_out, r_vector_valid;
  logic [VEC_W-1:0]   r_vector;

  logic [NUM_IRQ-1:0] w_pend, w_isr_clr, w_isr_set, w_irr_clr, w_irr_nxt, w_isr_nxt;
  logic               w_cand_found, w_svc_found;
  logic [IDX_W-1:0]   w_cand_idx, w_cand_rank, w_svc_idx, w_svc_rank;
  logic [IDX_W-1:0]   w_ptr_nxt, w_ack_id_nxt;
  logic               w_spur_nxt, w_int_nxt, w_vv_nxt;
  logic [VEC_W-1:0]   w_vec_nxt;

  // Line index holding priority rank k; rank 0 is the line just after lowest_ptr.
  function automatic logic [IDX_W-1:0] f_rot(input logic [IDX_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + 1 + k;
    if (s >= NUM_IRQ) s = s - NUM_IRQ;
    return IDX_W'(s);
  endfunction

  assign w_pend = r_irr & ~r_imr;

  always_comb begin
    w_cand_found = 1'b0;
    w_cand_idx   = '0;
    w_cand_rank  = '0;
    w_svc_found  = 1'b0;
    w_svc_idx    = '0;
    w_svc_rank   = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!w_cand_found && w_pend[f_rot(r_lowest_ptr, k)]) begin
        w_cand_found = 1'b1;
        w_cand_idx   = f_rot(r_lowest_ptr, k);
        w_cand_rank  = IDX_W'(k);
      end
      if (!w_svc_found && r_isr[f_rot(r_lowest_ptr, k)]) begin
        w_svc_found = 1'b1;
        w_svc_idx   = f_rot(r_lowest_ptr, k);
        w_svc_rank  = IDX_W'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_isr_clr    = '0;
    w_isr_set    = '0;
    w_irr_clr    = '0;
    w_ptr_nxt    = r_lowest_ptr;
    w_ack_id_nxt = r_ack_id;
    w_spur_nxt   = r_spurious;
    w_int_nxt    = 1'b0;
    w_vv_nxt     = 1'b0;
    w_vec_nxt    = r_vector;

    if (eoi_valid) begin
      if (eoi_specific) begin
        if (int'(eoi_id) < NUM_IRQ) begin
          w_isr_clr[eoi_id] = 1'b1;
          if (eoi_rotate) w_ptr_nxt = eoi_id;
        end
      end else if (w_svc_found) begin
        w_isr_clr[w_svc_idx] = 1'b1;
        if (eoi_rotate) w_ptr_nxt = w_svc_idx;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (inta_pulse) begin
          w_state_nxt = S_ACK1;
          if (w_cand_found) begin
            w_ack_id_nxt          = w_cand_idx;
            w_spur_nxt            = 1'b0;
            w_isr_set[w_cand_idx] = 1'b1;
            if (!level_mode) w_irr_clr[w_cand_idx] = 1'b1;
          end else begin
            w_ack_id_nxt = IDX_W'(NUM_IRQ - 1);
            w_spur_nxt   = 1'b1;
          end
        end else begin
          w_int_nxt = w_cand_found && (!w_svc_found || (w_cand_rank < w_svc_rank));
        end
      end
      S_ACK1: begin
        if (inta_pulse) begin
          w_state_nxt = S_IDLE;
          w_vv_nxt    = 1'b1;
          w_vec_nxt   = {vector_base, r_ack_id};
          if (auto_eoi && !r_spurious) begin
            w_isr_clr[r_ack_id] = 1'b1;
            if (rotate_on_aeoi) w_ptr_nxt = r_ack_id;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // EOI clears land before the acknowledge set, so a same-bit collision leaves it set.
  assign w_isr_nxt = (r_isr & ~w_isr_clr) | w_isr_set;
  assign w_irr_nxt = level_mode ? irq_in : ((r_irr | (irq_in & ~r_irq_q)) & ~w_irr_clr);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_irq_q        <= '0;
      r_irr          <= '0;
      r_isr          <= '0;
      r_imr          <= '1;
      r_lowest_ptr   <= IDX_W'(NUM_IRQ - 1);
      r_ack_id       <= '0;
      r_spurious     <= 1'b0;
      r_int_out      <= 1'b0;
      r_vector_valid <= 1'b0;
      r_vector       <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_irq_q        <= irq_in;
      r_irr          <= w_irr_nxt;
      r_isr          <= w_isr_nxt;
      if (imr_wr) r_imr <= imr_data;
      r_lowest_ptr   <= w_ptr_nxt;
      r_ack_id       <= w_ack_id_nxt;
      r_spurious     <= w_spur_nxt;
      r_int_out      <= w_int_nxt;
      r_vector_valid <= w_vv_nxt;
      r_vector       <= w_vec_nxt;
    end
  end

  assign int_out      = r_int_out;
  assign vector_valid = r_vector_valid;
  assign vector       = r_vector;
  assign irr          = r_irr;
  assign isr          = r_isr;
  assign imr          = r_imr;

endmodule

// File: tb/tb_irq_priority_controller.sv
// tb/tb_irq_priority_controller.sv - directed self-checking bench for irq_priority_controller
module tb_irq_priority_controller;

  logic       clock;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       level_mode;
  logic [4:0] vector_base;
  logic       imr_wr;
  logic [7:0] imr_data;
  logic       auto_eoi;
  logic       rotate_on_aeoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_id;
  logic       eoi_rotate;
  logic       inta_pulse;
  logic       int_out;
  logic       vector_valid;
  logic [7:0] vector;
  logic [7:0] irr, isr, imr;

  int n_pass  = 0;
  int n_total = 0;

  irq_priority_controller #(.NUM_IRQ(8), .IDX_W(3), .VEC_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .irq_in(irq_in), .level_mode(level_mode),
    .vector_base(vector_base), .imr_wr(imr_wr), .imr_data(imr_data),
    .auto_eoi(auto_eoi), .rotate_on_aeoi(rotate_on_aeoi), .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific), .eoi_id(eoi_id), .eoi_rotate(eoi_rotate),
    .inta_pulse(inta_pulse), .int_out(int_out), .vector_valid(vector_valid),
    .vector(vector), .irr(irr), .isr(isr), .imr(imr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic ack();
    inta_pulse = 1'b1;
    tick(2);
    inta_pulse = 1'b0;
  endtask

  task automatic eoi_spec(input logic [2:0] id);
    eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_id = id;
    tick();
    eoi_valid = 1'b0; eoi_specific = 1'b0;
  endtask

  task automatic write_imr(input logic [7:0] m);
    imr_wr = 1'b1; imr_data = m;
    tick();
    imr_wr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; irq_in = '0; level_mode = 1'b0; vector_base = 5'b10101;
    imr_wr = 1'b0; imr_data = '0; auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_id = '0; eoi_rotate = 1'b0;
    inta_pulse = 1'b0;
    tick(2);
    check("rst_int_out", int_out, 0);
    check("rst_irr", irr, 8'h00);
    check("rst_isr", isr, 8'h00);
    check("rst_imr", imr, 8'hFF);
    check("rst_vv", vector_valid, 0);
    check("rst_vector", vector, 8'h00);
    reset_n = 1'b1;
    write_imr(8'h00);

    // basic edge request, acknowledge, specific EOI
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    check("edge_irr_set", irr, 8'h01);
    check("edge_int_lat", int_out, 0);
    tick();
    check("edge_int_high", int_out, 1);
    ack();
    check("edge_vv", vector_valid, 1);
    check("edge_vector", vector, 8'hA8);
    check("edge_isr", isr, 8'h01);
    check("edge_irr_clr", irr, 8'h00);
    tick();
    check("vv_one_cycle", vector_valid, 0);
    check("vector_hold", vector, 8'hA8);
    eoi_spec(3'd0);
    check("eoi0_isr", isr, 8'h00);

    // fully nested
    irq_in = 8'h10; tick(); irq_in = 8'h00; tick();
    ack();
    check("nest_ack4", vector, 8'hAC);
    irq_in = 8'h38; tick(); irq_in = 8'h00; tick();
    check("nest_int_irq3", int_out, 1);
    ack();
    check("nest_vec3", vector, 8'hAB);
    check("nest_isr18", isr, 8'h18);
    check("nest_irr30", irr, 8'h30);
    tick();
    check("nest_blocked", int_out, 0);
    eoi_spec(3'd3);
    tick();
    check("nest_eq_blocked", int_out, 0);
    eoi_spec(3'd4);
    tick();
    check("nest_int_irq4", int_out, 1);
    ack();
    check("nest_vec4", vector, 8'hAC);
    eoi_spec(3'd4);
    tick();
    check("nest_int_irq5", int_out, 1);
    ack();
    check("nest_vec5", vector, 8'hAD);
    eoi_spec(3'd5);
    check("nest_isr_clear", isr, 8'h00);

    // auto EOI sweep over all lines
    auto_eoi = 1'b1;
    irq_in = 8'hFF; tick(); irq_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ack();
      check("aeoi_vector", vector, 32'hA8 + i);
      check("aeoi_isr", isr, 8'h00);
    end
    check("aeoi_irr", irr, 8'h00);

    // rotation on auto EOI
    rotate_on_aeoi = 1'b1;
    irq_in = 8'h05; tick(); irq_in = 8'h00;
    ack();
    check("rot_first0", vector, 8'hA8);
    ack();
    check("rot_next2", vector, 8'hAA);
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    ack();
    check("rot_irq0", vector, 8'hA8);
    irq_in = 8'h02; tick(); irq_in = 8'h01; tick(); irq_in = 8'h00;
    check("rot_irr03", irr, 8'h03);
    ack();
    check("rot_irq1_wins", vector, 8'hA9);
    ack();
    check("rot_then0", vector, 8'hA8);
    auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;

    // spurious with everything masked
    write_imr(8'hFF);
    irq_in = 8'h01; tick(); irq_in = 8'h00; tick(2);
    check("mask_int_low", int_out, 0);
    ack();
    check("spur_vector", vector, 8'hAF);
    check("spur_isr", isr, 8'h00);

    // level mode holds the request through acknowledge
    level_mode = 1'b1;
    write_imr(8'h00);
    irq_in = 8'h04; tick(2);
    check("lvl_int_high", int_out, 1);
    ack();
    check("lvl_vector", vector, 8'hAA);
    check("lvl_isr", isr, 8'h04);
    check("lvl_irr_held", irr, 8'h04);
    eoi_valid = 1'b1; tick(); eoi_valid = 1'b0;
    check("ns_eoi_isr", isr, 8'h00);

    // reset in the middle of an acknowledge
    tick();
    inta_pulse = 1'b1; tick(); inta_pulse = 1'b0;
    check("mid_isr_set", isr, 8'h04);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check("mid_rst_int", int_out, 0);
    check("mid_rst_isr", isr, 8'h00);
    check("mid_rst_imr", imr, 8'hFF);
    inta_pulse = 1'b1; tick();
    check("post_rst_idle", vector_valid, 0);
    tick(); inta_pulse = 1'b0;
    check("post_rst_vv", vector_valid, 1);
    check("post_rst_vec", vector, 8'hAF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/irq_priority_controller.md
Name: irq_priority_controller

Overview:
- Parametrised synchronous interrupt controller core, next generation of the 8259A-style controller.
- Supports NUM_IRQ request lines, edge or level triggering, per-line masking and fully nested priority.
- Priority is rotating; EOI is specific, non-specific or automatic.
- Sits between peripheral request lines and the CPU-side bus/ACK logic. Presents int_out and a vector on a two-pulse acknowledge sequence.

Parameters:
- NUM_IRQ, 8, number of request lines (2..32).
- IDX_W, $clog2(NUM_IRQ), width of a line index.
- VEC_W, 8, vector width; vector = {vector_base, index}, so VEC_W > IDX_W.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- irq_in  in  NUM_IRQ  raw request lines, already synchronous to clock.
- level_mode  in  1  1 = level triggered, 0 = edge triggered.
- vector_base  in  VEC_W-IDX_W  upper vector bits.
- imr_wr  in  1  single-cycle strobe that loads imr from imr_data.
- imr_data  in  NUM_IRQ  mask value; 1 = masked.
- auto_eoi  in  1  clear the ISR bit at the end of the acknowledge sequence.
- rotate_on_aeoi  in  1  with auto_eoi set, make the acknowledged line lowest priority.
- eoi_valid  in  1  single-cycle EOI command strobe.
- eoi_specific  in  1  1 = specific EOI using eoi_id, 0 = non-specific.
- eoi_id  in  IDX_W  line index for a specific EOI.
- eoi_rotate  in  1  with eoi_valid, make the cleared line lowest priority.
- inta_pulse  in  1  single-cycle acknowledge strobe; one acknowledge = two strobes.
- int_out  out  1  registered interrupt request to the CPU.
- vector_valid  out  1  one-cycle strobe; vector is valid when it is high.
- vector  out  VEC_W  {vector_base, acknowledged index}.
- irr, isr, imr  out  NUM_IRQ each  status readback.

Behaviour:
- Reset (reset_n=0 at a clock edge): irr=0, isr=0, imr=all ones, irq_q=0, lowest_ptr=NUM_IRQ-1, FSM=IDLE, int_out=0, vector_valid=0, vector=0. Reset wins over every other input, including mid-acknowledge.
- irq_q is irq_in registered every cycle.
- Edge mode: irr[i] is set when irq_in[i]=1 and irq_q[i]=0. It clears only when line i wins ACK1.
- Level mode: irr[i] is loaded from irq_in[i] every cycle; ACK1 does not clear it.
- Priority order starts at (lowest_ptr+1) mod NUM_IRQ and wraps. Reset order: IRQ0 highest, IRQ(NUM_IRQ-1) lowest.
- cand = highest-priority set bit of (irr & ~imr). svc = highest-priority set bit of isr.
- int_out next = (FSM==IDLE) and cand exists and (isr==0 or cand is higher priority than svc). This is fully nested; lines equal to or below the in-service line are blocked.
- Latency: irq_in rises at edge k, irr is set at k+1, int_out is high at k+2.
- Acknowledge FSM, IDLE -> ACK1 -> IDLE:
  - IDLE, inta_pulse=1: latch cand into ack_id, set isr[ack_id], clear irr[ack_id] in edge mode, force int_out=0, go to ACK1.
  - IDLE, inta_pulse=1 with no cand (spurious): ack_id=NUM_IRQ-1, isr and irr unchanged, spurious flag set, go to ACK1.
  - ACK1, inta_pulse=1: vector_valid=1 for one cycle with vector={vector_base, ack_id}. If auto_eoi is set and the acknowledge was not spurious, clear isr[ack_id]. If rotate_on_aeoi is also set, lowest_ptr=ack_id. Return to IDLE.
  - vector holds its value until the next vector_valid.
- Non-specific EOI clears the svc bit; no-op if isr==0. Specific EOI clears isr[eoi_id]; ignored if eoi_id>=NUM_IRQ.
- eoi_rotate with an effective EOI sets lowest_ptr to the cleared index.
- Same-cycle EOI and ACK1 entry: apply the EOI to isr first, then set the acknowledged bit. If the same bit is targeted, the bit ends set.
- Same-cycle edge and ACK1 clear on the same line: the clear wins (request is consumed).
- imr_wr takes effect on the next cycle's cand. Masking does not affect isr. Masking a line during ACK1 does not change the latched ack_id.

Test Plan:
- Edge mode, imr=0, vector_base=5'b10101, pulse irq_in=8'h01 -> int_out high 2 cycles later. Two inta_pulse strobes -> vector=8'hA8, isr=8'h01, irr=0. Specific EOI id 0 -> isr=0.
- Fully nested: ack IRQ4, then raise IRQ5, IRQ4, IRQ3 -> int_out high only for IRQ3. Ack gives vector index 3, isr=8'h18. EOI 3 then EOI 4 -> second IRQ4 acked. Then EOI 4, ack IRQ5, EOI 5 -> isr=0.
- auto_eoi=1, irq_in=8'hFF edge, eight acknowledges -> vector indices 0..7 in order, isr=0 after each, irr=0 at end.
- Rotation: auto_eoi=1, rotate_on_aeoi=1, irr=8'h05 -> first ack index 0, lowest_ptr=0; next ack index 2. Raise IRQ0 again after IRQ1 is pending -> IRQ1 wins.
- Spurious and masking: imr=8'hFF, irq_in=8'h01 -> int_out stays 0. Two inta_pulse strobes -> vector index 7, isr=0. Level mode with IRQ2 held high -> irr[2] stays 1 after ack.
- Reset mid-ACK1 -> next cycle int_out=0, isr=0, imr=8'hFF. The following inta_pulse is treated as IDLE.
